// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int          INSTRUCTION_DEPTH = 256;
    localparam logic [31:0] NOP               = 32'h0000_0013;

    // Width of the outstanding/discard counters for a given buffer depth
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small register-based synchronous FIFO with flush; head is readable in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define which entries are live
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == PW'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: PC sequencing, credit-limited IMEM requests, wrong-path discard, decode buffer.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int             AW         = $clog2(INSTRUCTION_DEPTH),
    parameter int             IW         = 32,
    parameter int             FIFO_DEPTH = 2,
    parameter logic [AW-1:0]  RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [AW-1:0] dec_pc,
    output logic [IW-1:0] dec_instr
);

    localparam int            CW      = cnt_width(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);

    logic [AW-1:0]    pc_reg, pc_next;
    logic [CW-1:0]    outstanding_reg, outstanding_next;
    logic [CW-1:0]    discard_reg, discard_next;
    logic [CW:0]      credit_used;
    logic             req_fire, rsp_drop, rsp_keep, dec_fire;

    logic [CW-1:0]    buf_count, tag_count;
    logic             buf_full, buf_empty, tag_full, tag_empty;
    logic [AW+IW-1:0] buf_head;
    logic [AW-1:0]    tag_head;
    logic             unused_status;

    // Credits cover both buffered entries and responses still in flight
    assign credit_used    = {1'b0, buf_count} + {1'b0, outstanding_reg};
    assign imem_req_valid = !rst && (credit_used < DEPTH_L);
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (discard_reg != '0);
    assign rsp_keep       = imem_rsp_valid && !rsp_drop;

    assign dec_valid = !buf_empty;
    assign dec_fire  = dec_valid && dec_ready;
    assign dec_pc    = buf_empty ? '0 : buf_head[IW +: AW];
    assign dec_instr = buf_empty ? IW'(NOP) : buf_head[IW-1:0];

    assign unused_status = ^{buf_full, tag_full, tag_empty, tag_count};

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        if (req_fire) begin
            pc_next          = pc_reg + 1'b1;
            outstanding_next = outstanding_next + CW'(1);
        end
        if (imem_rsp_valid) begin
            outstanding_next = outstanding_next - CW'(1);
            if (rsp_drop) discard_next = discard_reg - CW'(1);
        end
        // Everything still in flight after this cycle belongs to the old path
        if (redirect_valid) begin
            pc_next      = redirect_pc;
            discard_next = outstanding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    fetch_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .srst  (rst),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (redirect_valid),
        .din   (pc_reg),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count),
        .head  (tag_head)
    );

    fetch_fifo #(.WIDTH(AW+IW), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .srst  (rst),
        .push  (rsp_keep),
        .pop   (dec_fire),
        .flush (redirect_valid),
        .din   ({tag_head, imem_rsp_data}),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count),
        .head  (buf_head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order IMEM model.
module tb_instr_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid, imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data  = '0;
    logic          dec_valid, dec_ready;
    logic [AW-1:0] dec_pc;
    logic [IW-1:0] dec_instr;

    logic          w_req_valid, w_dec_valid;
    logic [AW-1:0] w_req_addr, w_dec_pc;
    logic [IW-1:0] w_dec_instr;

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    int cyc    = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;
    pend_t pq[$];

    instr_fetch_unit #(.AW(AW), .IW(IW), .FIFO_DEPTH(2), .RESET_PC(8'd0)) u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr)
    );

    // Second instance near the top of the address space, fed the same inputs
    instr_fetch_unit #(.AW(AW), .IW(IW), .FIFO_DEPTH(2), .RESET_PC(8'd254)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready),
        .dec_pc(w_dec_pc), .dec_instr(w_dec_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 | {24'h0, a};
    endfunction

    always begin
        @(negedge clk);
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pq[0].addr);
            void'(pq.pop_front());
        end
        if (imem_req_valid && imem_req_ready) pq.push_back('{imem_req_addr, cyc + lat});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", imem_req_addr); end
        checks++; if (w_req_addr !== 8'd254) begin errors++; $display("FAIL reset_pc_wrap: got %0h expected fe", w_req_addr); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        checks++; if (dec_pc !== 8'd0) begin errors++; $display("FAIL reset_dec_pc: got %0h expected 0", dec_pc); end
        checks++; if (dec_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_dec_instr: got %h expected 00000013", dec_instr); end
        @(negedge clk);
    endtask

    task automatic test_sequential();
        logic [AW-1:0] exp_req = 8'd0, exp_dec = 8'd0, w_exp_req = 8'd254, w_exp_dec = 8'd254;
        int first_fire = -1, nfire = 0, ndec = 0, w_nfire = 0, w_ndec = 0;
        lat = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            rst = 1'b0;
            #2;
            if (imem_req_valid && imem_req_ready) begin
                if (first_fire < 0) first_fire = c;
                if (nfire == 1) begin
                    checks++; if (c !== first_fire + 1) begin errors++; $display("FAIL seq_back_to_back: got cycle %0d expected %0d", c, first_fire + 1); end
                end
                checks++; if (imem_req_addr !== exp_req) begin errors++; $display("FAIL seq_req_addr: got %0h expected %0h", imem_req_addr, exp_req); end
                exp_req++; nfire++;
            end
            if (w_req_valid && imem_req_ready && w_nfire < 4) begin
                checks++; if (w_req_addr !== w_exp_req) begin errors++; $display("FAIL wrap_req_addr: got %0h expected %0h", w_req_addr, w_exp_req); end
                w_exp_req++; w_nfire++;
            end
            if (dec_valid && dec_ready) begin
                $display("seq  dec pc=%0h instr=%h", dec_pc, dec_instr);
                if (ndec == 0) begin
                    checks++; if (c !== first_fire + 2) begin errors++; $display("FAIL seq_first_dec_latency: got cycle %0d expected %0d", c, first_fire + 2); end
                end
                checks++; if (dec_pc !== exp_dec) begin errors++; $display("FAIL seq_dec_pc: got %0h expected %0h", dec_pc, exp_dec); end
                checks++; if (dec_instr !== mem_word(exp_dec)) begin errors++; $display("FAIL seq_dec_instr: got %h expected %h", dec_instr, mem_word(exp_dec)); end
                exp_dec++; ndec++;
            end
            if (w_dec_valid && dec_ready && w_ndec < 4) begin
                $display("wrap dec pc=%0h", w_dec_pc);
                checks++; if (w_dec_pc !== w_exp_dec) begin errors++; $display("FAIL wrap_dec_pc: got %0h expected %0h", w_dec_pc, w_exp_dec); end
                w_exp_dec++; w_ndec++;
            end
        end
        checks++; if (ndec < 6) begin errors++; $display("FAIL seq_dec_count: got %0d expected >=6", ndec); end
        checks++; if (w_ndec < 4) begin errors++; $display("FAIL wrap_dec_count: got %0d expected >=4", w_ndec); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] exp_dec = 8'd0;
        int nfire = 0, ndec = 0;
        lat = 1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            rst = 1'b0; dec_ready = 1'b0;
            #2;
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== AW'(nfire)) begin errors++; $display("FAIL bp_req_addr: got %0h expected %0h", imem_req_addr, nfire); end
                nfire++;
            end
        end
        checks++; if (nfire !== 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", nfire); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'd0) begin errors++; $display("FAIL bp_head: got valid=%b pc=%0h expected valid=1 pc=0", dec_valid, dec_pc); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            dec_ready = 1'b1;
            #2;
            if (dec_valid && dec_ready) begin
                $display("bp   dec pc=%0h instr=%h", dec_pc, dec_instr);
                checks++; if (dec_pc !== exp_dec) begin errors++; $display("FAIL bp_dec_pc: got %0h expected %0h", dec_pc, exp_dec); end
                exp_dec++; ndec++;
            end
        end
        checks++; if (ndec < 3) begin errors++; $display("FAIL bp_dec_count: got %0d expected >=3", ndec); end
    endtask

    task automatic test_redirect_inflight();
        bit seen = 0;
        lat = 3;
        do_reset();
        rst = 1'b0;
        #2;
        checks++; if (!(imem_req_valid && imem_req_addr === 8'd0)) begin errors++; $display("FAIL rd_req0: got valid=%b addr=%0h expected valid=1 addr=0", imem_req_valid, imem_req_addr); end
        @(negedge clk); #2;
        checks++; if (!(imem_req_valid && imem_req_addr === 8'd1)) begin errors++; $display("FAIL rd_req1: got valid=%b addr=%0h expected valid=1 addr=1", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_credit: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        checks++; if (imem_req_addr !== 8'h40) begin errors++; $display("FAIL rd_new_pc: got %0h expected 40", imem_req_addr); end
        for (int c = 0; c < 15 && !seen; c++) begin
            @(negedge clk); #2;
            if (dec_valid) begin
                seen = 1;
                $display("rd   dec pc=%0h instr=%h", dec_pc, dec_instr);
                checks++; if (dec_pc !== 8'h40) begin errors++; $display("FAIL rd_dec_pc: got %0h expected 40", dec_pc); end
                checks++; if (dec_instr !== mem_word(8'h40)) begin errors++; $display("FAIL rd_dec_instr: got %h expected %h", dec_instr, mem_word(8'h40)); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL rd_timeout: got no dec_valid expected pc 40"); end
    endtask

    task automatic test_redirect_same_cycle();
        bit found = 0, seen = 0;
        lat = 1;
        do_reset();
        rst = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk); #2;
            if (imem_req_valid && imem_req_ready && imem_req_addr === 8'd5) begin
                found = 1;
                redirect_valid = 1'b1; redirect_pc = 8'h20;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL sc_find_pc5: got none expected request at pc 5"); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL sc_flush: got dec_valid=%b expected 0", dec_valid); end
        checks++; if (imem_req_addr !== 8'h20) begin errors++; $display("FAIL sc_new_pc: got %0h expected 20", imem_req_addr); end
        for (int c = 0; c < 15 && !seen; c++) begin
            @(negedge clk); #2;
            if (dec_valid) begin
                seen = 1;
                $display("sc   dec pc=%0h instr=%h", dec_pc, dec_instr);
                checks++; if (dec_pc !== 8'h20) begin errors++; $display("FAIL sc_dec_pc: got %0h expected 20", dec_pc); end
                checks++; if (dec_instr !== mem_word(8'h20)) begin errors++; $display("FAIL sc_dec_instr: got %h expected %h", dec_instr, mem_word(8'h20)); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL sc_timeout: got no dec_valid expected pc 20"); end
    endtask

    task automatic test_reset_midflight();
        logic [AW-1:0] exp_dec = 8'd0;
        int ndec = 0;
        lat = 2;
        do_reset();
        rst = 1'b0;
        #2;
        checks++; if (!(imem_req_valid && imem_req_addr === 8'd0)) begin errors++; $display("FAIL rm_req0: got valid=%b addr=%0h expected valid=1 addr=0", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req_in_reset: got %b expected 0", imem_req_valid); end
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rm_dropped: got dec_valid=%b pc=%0h expected 0", dec_valid, dec_pc); end
        checks++; if (imem_req_addr !== 8'd0) begin errors++; $display("FAIL rm_pc: got %0h expected 0", imem_req_addr); end
        for (int c = 0; c < 20 && ndec < 3; c++) begin
            @(negedge clk); #2;
            if (dec_valid && dec_ready) begin
                $display("rm   dec pc=%0h instr=%h", dec_pc, dec_instr);
                checks++; if (dec_pc !== exp_dec) begin errors++; $display("FAIL rm_dec_pc: got %0h expected %0h", dec_pc, exp_dec); end
                exp_dec++; ndec++;
            end
        end
        if (ndec < 3) begin checks++; errors++; $display("FAIL rm_timeout: got %0d decodes expected 3", ndec); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
